load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit and the data memory.
//   mem_req    : request valid, held until mem_gnt
//   mem_we     : write strobe (1 = store)
//   mem_addr   : word-aligned byte address
//   mem_be     : byte enables
//   mem_wdata  : lane-replicated store data
//   mem_gnt    : memory accepts the request
//   mem_rvalid : read data valid on mem_rdata
//   mem_rdata  : read data
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for the memory stage. It takes one load or store at a
// time from the pipeline, issues it on the memory bus and stalls stages F..M
// until the access completes.
//   clk, reset        : clock, asynchronous active-low reset
//   MemReadM/WriteM   : load / store request (both together is illegal)
//   funct3M           : size/sign (B, H, W, BU, HU)
//   AddrM, WriteDataM : byte address, LSB-justified store data
//   ReadDataM         : extended load result, valid in DONE
//   StallM            : hold the pipeline
//   MisalignM         : one-cycle pulse, access rejected
//   BusErrM           : one-cycle pulse (in DONE) after a read timeout
//   mem               : memory bus (master side)
module load_store_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [2:0]                funct3M,
    input  logic [31:0]               AddrM,
    input  logic [31:0]               WriteDataM,
    output logic [31:0]               ReadDataM,
    output logic                      StallM,
    output logic                      MisalignM,
    output logic                      BusErrM,
    load_store_unit_if.master         mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q, ld_ext, ld_sh;
    logic        buserr_q;
    logic        op, mis, latch, capture, timeout;

    // Request decode and store formatting, straight from the pipeline inputs.
    always_comb begin
        op  = MemReadM | MemWriteM;
        mis = 1'b0;
        if (MemReadM && MemWriteM)
            mis = 1'b1;
        else if (MemWriteM && !(funct3M inside {3'b000, 3'b001, 3'b010}))
            mis = 1'b1;
        else if (MemReadM && (funct3M inside {3'b011, 3'b110, 3'b111}))
            mis = 1'b1;
        else if (funct3M[1:0] == 2'b01 && AddrM[0])
            mis = 1'b1;
        else if (funct3M[1:0] == 2'b10 && AddrM[1:0] != 2'b00)
            mis = 1'b1;

        req_d.addr = AddrM;
        req_d.f3   = funct3M;
        req_d.we   = MemWriteM;
        case (funct3M[1:0])
            2'b00: begin
                req_d.be    = 4'b0001 << AddrM[1:0];
                req_d.wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                req_d.be    = 4'b0011 << {AddrM[1], 1'b0};
                req_d.wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                req_d.be    = 4'b1111;
                req_d.wdata = WriteDataM;
            end
        endcase
    end

    // Load lane extraction uses the latched address, not the live one.
    always_comb begin
        ld_sh = mem.mem_rdata >> {req_q.addr[1:0], 3'b000};
        case (req_q.f3)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
            3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        StallM      = 1'b0;
        MisalignM   = 1'b0;
        mem.mem_req = 1'b0;
        latch       = 1'b0;
        capture     = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            IDLE: begin
                if (op && mis) begin
                    MisalignM = 1'b1;
                end else if (op) begin
                    StallM  = 1'b1;
                    latch   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem.mem_req = 1'b1;
                StallM      = 1'b1;
                if (mem.mem_gnt)
                    state_d = req_q.we ? DONE : WAIT;
            end
            WAIT: begin
                StallM = 1'b1;
                // Data arriving on the final wait cycle beats the timeout.
                if (mem.mem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Combinational pulses must also read as inactive while in reset.
        if (!reset) begin
            StallM    = 1'b0;
            MisalignM = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buserr_q <= timeout;
            if (latch)
                req_q <= req_d;
            cnt_q <= (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
            if (capture)
                rdata_q <= ld_ext;
            else if (timeout)
                rdata_q <= '0;
        end
    end

    assign ReadDataM     = rdata_q;
    assign BusErrM       = buserr_q;
    assign mem.mem_we    = req_q.we;
    assign mem.mem_addr  = {req_q.addr[31:2], 2'b00};
    assign mem.mem_be    = req_q.be;
    assign mem.mem_wdata = req_q.wdata;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] AddrM, WriteDataM, ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    int          checks = 0;
    int          errors = 0;

    load_store_unit_if mif ();

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .mem(mif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model: access rules as plain arithmetic ----
    function automatic int acc_size(input logic [2:0] f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction

    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
        if (rd && wr) return 0;
        if (!rd && !wr) return 0;
        if (wr && f3 > 2) return 0;
        if (rd && !(f3 <= 2 || f3 == 4 || f3 == 5)) return 0;
        return (addr % acc_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = acc_size(f3);
        return ((32'd1 << n) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = acc_size(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int          bits = 8 * acc_size(f3);
        logic [31:0] mask, v;
        if (bits == 32) return rdata;
        mask = (32'd1 << bits) - 32'd1;
        v = (rdata >> (8 * (addr % 4))) & mask;
        if (f3 < 4 && ((v >> (bits - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    // One pipeline op: gw = REQ cycles without grant before grant,
    // rw = WAIT cycles before rvalid (rw >= MAX_WAIT means never).
    task automatic lsu_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int gw, input int rw);
        bit ok      = m_legal(rd, wr, f3, addr);
        bit tmo     = 0;
        int stalls  = 0;
        int waits   = 0;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; AddrM = addr; WriteDataM = wd;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'($urandom % 2); mif.mem_rdata = $urandom;
        #1;
        if (!ok) begin
            chk("mis_pulse", MisalignM, 1);
            chk("mis_stall", StallM, 0);
            chk("mis_req", mif.mem_req, 0);
            @(negedge clk);
            MemReadM = 0; MemWriteM = 0; mif.mem_rvalid = 0;
            #1;
            chk("mis_one_cycle", MisalignM, 0);
            chk("mis_no_req", mif.mem_req, 0);
            chk("mis_idle_stall", StallM, 0);
            return;
        end
        chk("idle_stall", StallM, 1);
        chk("idle_mis", MisalignM, 0);
        chk("idle_req", mif.mem_req, 0);
        if (StallM === 1'b1) stalls++;
        for (int i = 0; i <= gw; i++) begin
            @(negedge clk);
            mif.mem_gnt = (i == gw); mif.mem_rvalid = 1'($urandom % 2); mif.mem_rdata = $urandom;
            #1;
            chk("req_valid", mif.mem_req, 1);
            chk("req_addr", mif.mem_addr, addr & 32'hFFFF_FFFC);
            chk("req_be", mif.mem_be, m_be(f3, addr));
            chk("req_we", mif.mem_we, wr);
            if (wr) chk("req_wdata", mif.mem_wdata, m_wdata(f3, wd));
            if (StallM === 1'b1) stalls++;
        end
        if (rd) begin
            for (int i = 0; i < MAX_WAIT; i++) begin
                @(negedge clk);
                mif.mem_gnt = 1'($urandom % 2);
                mif.mem_rvalid = (i == rw);
                mif.mem_rdata = (i == rw) ? rdata : $urandom;
                #1;
                waits++;
                chk("wait_req", mif.mem_req, 0);
                if (StallM === 1'b1) stalls++;
                if (i == rw) break;
                if (i == MAX_WAIT - 1) tmo = 1;
            end
        end
        @(negedge clk);
        mif.mem_gnt = 0; mif.mem_rvalid = 1'($urandom % 2); mif.mem_rdata = $urandom;
        #1;
        chk("done_stall", StallM, 0);
        chk("stall_cycles", stalls, 1 + (gw + 1) + waits);
        chk("done_buserr", BusErrM, tmo);
        chk("done_req", mif.mem_req, 0);
        if (rd) chk("done_rdata", ReadDataM, tmo ? 32'd0 : m_load(f3, addr, rdata));
        @(negedge clk);
        MemReadM = 0; MemWriteM = 0; mif.mem_rvalid = 0;
        #1;
        chk("idle_buserr_cleared", BusErrM, 0);
        chk("idle_after_done", StallM, 0);
    endtask

    initial begin
        reset = 0; MemReadM = 0; MemWriteM = 0; funct3M = 0; AddrM = 0; WriteDataM = 0;
        mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
        #3;
        chk("rst_stall", StallM, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_be", mif.mem_be, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_buserr", BusErrM, 0);
        @(negedge clk);
        reset = 1;

        // directed cases
        lsu_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);          // SW
        lsu_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 2);          // LB
        lsu_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 2);          // LBU
        lsu_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1, 0);          // SH
        lsu_op(1, 0, 3'b101, 32'h202, 32'h0, 32'hABCD0000, 0, 0);          // LHU
        lsu_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);                 // LW misaligned
        lsu_op(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0);                 // LH misaligned
        lsu_op(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);                 // read+write
        lsu_op(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0);                 // illegal store size
        lsu_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);                 // illegal load size
        lsu_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 1, MAX_WAIT);          // timeout
        lsu_op(1, 0, 3'b010, 32'h304, 32'h0, 32'h13579BDF, 0, MAX_WAIT-1); // data on last cycle

        // randomized ops
        for (int n = 0; n < 60; n++) begin
            int  k  = $urandom % 8;
            bit  rd = (k <= 4);
            bit  wr = (k == 0) || (k >= 5);
            lsu_op(rd, wr, 3'($urandom % 8), $urandom, $urandom, $urandom,
                   int'($urandom % 3), int'($urandom % (MAX_WAIT + 3)));
        end

        // reset in the middle of a load
        lsu_op(1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0, 0);
        @(negedge clk);
        MemReadM = 1; funct3M = 3'b010; AddrM = 32'h404; mif.mem_gnt = 0; mif.mem_rvalid = 0;
        @(negedge clk);
        mif.mem_gnt = 1;
        @(negedge clk);
        mif.mem_gnt = 0;
        @(negedge clk);
        #2 reset = 0;
        #1;
        chk("abort_stall", StallM, 0);
        chk("abort_mis", MisalignM, 0);
        chk("abort_req", mif.mem_req, 0);
        chk("abort_we", mif.mem_we, 0);
        chk("abort_be", mif.mem_be, 0);
        chk("abort_addr", mif.mem_addr, 0);
        chk("abort_rdata", ReadDataM, 0);
        chk("abort_buserr", BusErrM, 0);
        @(negedge clk);
        reset = 1; MemReadM = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("late_rvalid_rdata", ReadDataM, 0);
            chk("late_rvalid_stall", StallM, 0);
        end
        mif.mem_rvalid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
